// File: rtl/writeback_ctrl_pkg.sv
// writeback_ctrl_pkg: shared default widths and the queued writeback entry type
package writeback_ctrl_pkg;
    localparam int WB_DATA_W = 16;
    localparam int WB_ADDR_W = 3;
    typedef struct packed {
        logic [WB_ADDR_W-1:0] rd;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/writeback_ctrl_fifo.sv
// wb_fifo: per-source result queue; exposes each slot's tag and validity for pending-write tracking
module wb_fifo #(
    parameter int DEPTH = 2,
    parameter int W = 19,
    parameter int TW = 3
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         flush,
    input  logic                         push,
    input  logic                         pop,
    input  logic [W-1:0]                 din,
    output logic [W-1:0]                 dout,
    output logic                         full,
    output logic                         empty,
    output logic [DEPTH-1:0][TW-1:0]     tags,
    output logic [DEPTH-1:0]             slot_valid
);
    localparam int AW = $clog2(DEPTH);
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic [DEPTH-1:0][W-1:0] mem;
    logic push_ok;
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign push_ok = push & ~full;
    assign dout = mem[rd_ptr];
    always_ff @(posedge clk)
        if (push_ok) mem[wr_ptr] <= din;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push_ok);
            rd_ptr <= rd_ptr + AW'(pop);
            count <= count + (AW+1)'(push_ok) - (AW+1)'(pop);
        end
    // a slot is live when its distance from the read pointer is below the occupancy
    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        logic [AW-1:0] off;
        assign off = AW'(i) - rd_ptr;
        assign slot_valid[i] = {1'b0, off} < count;
        assign tags[i] = mem[i][W-1 -: TW];
    end
endmodule

// File: rtl/writeback_ctrl.sv
// writeback_ctrl: two-source (ALU/load) writeback arbiter into one register-file port.
// Define WB_R0_ZERO_EN to drop writes to register 0 (popped but never strobed, never busy).
module writeback_ctrl
    import writeback_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   alu_valid,
    output logic                   alu_ready,
    input  logic [ADDR_W-1:0]      alu_rd,
    input  logic [DATA_W-1:0]      alu_data,
    input  logic                   ld_valid,
    output logic                   ld_ready,
    input  logic [ADDR_W-1:0]      ld_rd,
    input  logic [DATA_W-1:0]      ld_data,
    output logic                   rf_write_enable,
    output logic [ADDR_W-1:0]      rf_write_addr,
    output logic [DATA_W-1:0]      rf_write_data,
    output logic [2**ADDR_W-1:0]   busy
);
    localparam int EW = ADDR_W + DATA_W;
    logic live, rr_ld;
    logic alu_full, ld_full, alu_empty, ld_empty;
    logic alu_push, ld_push, alu_pop, ld_pop, pop, pick_alu, wr_keep;
    logic [EW-1:0] alu_dout, ld_dout, sel;
    logic [FIFO_DEPTH-1:0][ADDR_W-1:0] alu_tags, ld_tags;
    logic [FIFO_DEPTH-1:0] alu_sv, ld_sv;
    assign alu_ready = live & ~alu_full;
    assign ld_ready = live & ~ld_full;
    assign alu_push = alu_valid & alu_ready & ~flush;
    assign ld_push = ld_valid & ld_ready & ~flush;
    // ALU wins when it is the only candidate or when the tie pointer favours it
    assign pick_alu = ~alu_empty & (ld_empty | ~rr_ld);
    assign pop = ~flush & ~(alu_empty & ld_empty);
    assign alu_pop = pop & pick_alu;
    assign ld_pop = pop & ~pick_alu;
    assign sel = pick_alu ? alu_dout : ld_dout;
`ifdef WB_R0_ZERO_EN
    assign wr_keep = sel[EW-1:DATA_W] != '0;
`else
    assign wr_keep = 1'b1;
`endif
    wb_fifo #(.DEPTH(FIFO_DEPTH), .W(EW), .TW(ADDR_W)) u_alu_q (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .push(alu_push), .pop(alu_pop), .din({alu_rd, alu_data}), .dout(alu_dout),
        .full(alu_full), .empty(alu_empty), .tags(alu_tags), .slot_valid(alu_sv)
    );
    wb_fifo #(.DEPTH(FIFO_DEPTH), .W(EW), .TW(ADDR_W)) u_ld_q (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .push(ld_push), .pop(ld_pop), .din({ld_rd, ld_data}), .dout(ld_dout),
        .full(ld_full), .empty(ld_empty), .tags(ld_tags), .slot_valid(ld_sv)
    );
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            live <= 1'b0;
            rr_ld <= 1'b0;
            rf_write_enable <= 1'b0;
            rf_write_addr <= '0;
            rf_write_data <= '0;
        end else begin
            live <= 1'b1;
            rf_write_enable <= pop & wr_keep;
            if (pop & ~alu_empty & ~ld_empty) rr_ld <= ~rr_ld;
            if (pop & wr_keep) {rf_write_addr, rf_write_data} <= sel;
        end
    always_comb begin
        busy = '0;
        for (int j = 0; j < FIFO_DEPTH; j++) begin
            if (alu_sv[j]) busy[alu_tags[j]] = 1'b1;
            if (ld_sv[j]) busy[ld_tags[j]] = 1'b1;
        end
        if (rf_write_enable) busy[rf_write_addr] = 1'b1;
`ifdef WB_R0_ZERO_EN
        busy[0] = 1'b0;
`endif
    end
endmodule

// File: tb/tb_writeback_ctrl.sv
// tb_writeback_ctrl: vector table, corner sequences and queue-model random run for writeback_ctrl
module tb_writeback_ctrl;
    import writeback_ctrl_pkg::*;
    localparam int D = 2;
    logic clk = 1'b0, reset_n = 1'b1, flush = 1'b0;
    logic alu_valid = 1'b0, ld_valid = 1'b0, alu_ready, ld_ready;
    logic [2:0] alu_rd = '0, ld_rd = '0, rf_write_addr;
    logic [15:0] alu_data = '0, ld_data = '0, rf_write_data;
    logic rf_write_enable;
    logic [7:0] busy;
    int n_chk = 0, n_fail = 0;
    always #5 clk = ~clk;

    writeback_ctrl #(.FIFO_DEPTH(D), .DATA_W(16), .ADDR_W(3)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .rf_write_enable(rf_write_enable), .rf_write_addr(rf_write_addr),
        .rf_write_data(rf_write_data), .busy(busy)
    );

    typedef struct packed {
        logic av; logic [2:0] ar; logic [15:0] ad;
        logic lv; logic [2:0] lr; logic [15:0] ld;
        logic fl; logic [29:0] exp;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(input logic av, input logic [2:0] ar, input logic [15:0] ad,
                                input logic lv, input logic [2:0] lr, input logic [15:0] ld,
                                input logic fl, input logic we, input logic [2:0] wa,
                                input logic [15:0] wd, input logic [7:0] b, input logic ra, input logic rl);
        vec_t v;
        v.av = av; v.ar = ar; v.ad = ad; v.lv = lv; v.lr = lr; v.ld = ld; v.fl = fl;
        v.exp = {we, wa, wd, b, ra, rl};
        return v;
    endfunction

    function automatic logic [29:0] obs();
        return {rf_write_enable, rf_write_addr, rf_write_data, busy, alu_ready, ld_ready};
    endfunction

    task automatic check(input string name, input logic [29:0] act, input logic [29:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {we,addr,data,busy,ardy,lrdy}=%h required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 1'b0; ld_valid = 1'b0; flush = 1'b0;
    endtask

    // reference: two FIFOs as queues, a tie-toggle bit and the last issued write
    wb_entry_t mq_a[$], mq_l[$];
    logic m_rr, m_we;
    logic [2:0] m_wa;
    logic [15:0] m_wd;

    task automatic model_reset();
        mq_a.delete(); mq_l.delete();
        m_rr = 1'b0; m_we = 1'b0; m_wa = '0; m_wd = '0;
    endtask

    task automatic model_step();
        bit ta, tl, have;
        wb_entry_t e, n;
        ta = alu_valid && mq_a.size() < D && !flush;
        tl = ld_valid && mq_l.size() < D && !flush;
        have = 0;
        m_we = 1'b0;
        if (flush) begin
            mq_a.delete(); mq_l.delete();
        end else begin
            if (mq_a.size() > 0 && mq_l.size() > 0) begin
                e = m_rr ? mq_l.pop_front() : mq_a.pop_front();
                m_rr = !m_rr;
                have = 1;
            end else if (mq_a.size() > 0) begin
                e = mq_a.pop_front(); have = 1;
            end else if (mq_l.size() > 0) begin
                e = mq_l.pop_front(); have = 1;
            end
            if (have)
`ifdef WB_R0_ZERO_EN
                if (e.rd != 3'd0)
`endif
                begin
                    m_we = 1'b1; m_wa = e.rd; m_wd = e.data;
                end
        end
        if (ta) begin n.rd = alu_rd; n.data = alu_data; mq_a.push_back(n); end
        if (tl) begin n.rd = ld_rd; n.data = ld_data; mq_l.push_back(n); end
    endtask

    function automatic logic [29:0] model_exp();
        logic [7:0] b;
        b = '0;
        foreach (mq_a[i]) b[mq_a[i].rd] = 1'b1;
        foreach (mq_l[i]) b[mq_l[i].rd] = 1'b1;
        if (m_we) b[m_wa] = 1'b1;
`ifdef WB_R0_ZERO_EN
        b[0] = 1'b0;
`endif
        return {m_we, m_wa, m_wd, b, mq_a.size() < D, mq_l.size() < D};
    endfunction

    logic [15:0] lvals[3];
    logic [15:0] got[$];

    initial begin
        int idx, cyc, n_str;
        bit seen_low, hs;
        lvals[0] = 16'h0A01; lvals[1] = 16'h0A02; lvals[2] = 16'h0A03;
        tbl.push_back(mk(1, 3, 16'hBEEF, 0, 0, 0,       0, 0, 0, 16'h0000, 8'h08, 1, 1));
        tbl.push_back(mk(0, 0, 0,        0, 0, 0,       0, 1, 3, 16'hBEEF, 8'h08, 1, 1));
        tbl.push_back(mk(0, 0, 0,        0, 0, 0,       0, 0, 3, 16'hBEEF, 8'h00, 1, 1));
        tbl.push_back(mk(1, 1, 16'h0011, 1, 2, 16'h0022, 0, 0, 3, 16'hBEEF, 8'h06, 1, 1));
        tbl.push_back(mk(1, 1, 16'h0101, 1, 2, 16'h0202, 0, 1, 1, 16'h0011, 8'h06, 1, 0));
        tbl.push_back(mk(1, 1, 16'h0303, 0, 0, 0,       0, 1, 2, 16'h0022, 8'h06, 0, 1));
        tbl.push_back(mk(0, 0, 0,        0, 0, 0,       0, 1, 1, 16'h0101, 8'h06, 1, 1));
        tbl.push_back(mk(0, 0, 0,        0, 0, 0,       0, 1, 2, 16'h0202, 8'h06, 1, 1));
        tbl.push_back(mk(0, 0, 0,        0, 0, 0,       0, 1, 1, 16'h0303, 8'h02, 1, 1));
        tbl.push_back(mk(0, 0, 0,        0, 0, 0,       0, 0, 1, 16'h0303, 8'h00, 1, 1));
        tbl.push_back(mk(1, 5, 16'h0555, 1, 6, 16'h0666, 0, 0, 1, 16'h0303, 8'h60, 1, 1));
        tbl.push_back(mk(1, 7, 16'h0777, 0, 0, 0,       1, 0, 1, 16'h0303, 8'h00, 1, 1));
        tbl.push_back(mk(0, 0, 0,        0, 0, 0,       0, 0, 1, 16'h0303, 8'h00, 1, 1));
`ifdef WB_R0_ZERO_EN
        tbl.push_back(mk(1, 0, 16'h1234, 0, 0, 0,       0, 0, 1, 16'h0303, 8'h00, 1, 1));
        tbl.push_back(mk(0, 0, 0,        0, 0, 0,       0, 0, 1, 16'h0303, 8'h00, 1, 1));
        tbl.push_back(mk(0, 0, 0,        0, 0, 0,       0, 0, 1, 16'h0303, 8'h00, 1, 1));
`else
        tbl.push_back(mk(1, 0, 16'h1234, 0, 0, 0,       0, 0, 1, 16'h0303, 8'h01, 1, 1));
        tbl.push_back(mk(0, 0, 0,        0, 0, 0,       0, 1, 0, 16'h1234, 8'h01, 1, 1));
        tbl.push_back(mk(0, 0, 0,        0, 0, 0,       0, 0, 0, 16'h1234, 8'h00, 1, 1));
`endif
        #1 reset_n = 1'b0;
        tick();
        check("in_reset", obs(), 30'd0);
        reset_n = 1'b1;
        tick();
        check("after_release", obs(), 30'b11);

        for (int i = 0; i < tbl.size(); i++) begin
            alu_valid = tbl[i].av; alu_rd = tbl[i].ar; alu_data = tbl[i].ad;
            ld_valid = tbl[i].lv; ld_rd = tbl[i].lr; ld_data = tbl[i].ld;
            flush = tbl[i].fl;
            tick();
            check($sformatf("vec%0d", i), obs(), tbl[i].exp);
        end
        idle();

        // reset dropped mid-operation with three entries still pending
        alu_valid = 1'b1; alu_rd = 1; alu_data = 16'h0AAA;
        ld_valid = 1'b1; ld_rd = 2; ld_data = 16'h0BBB;
        tick();
        alu_rd = 3; alu_data = 16'h0CCC; ld_rd = 4; ld_data = 16'h0DDD;
        tick();
        idle();
        #2 reset_n = 1'b0;
        #1 check("async_reset", obs(), 30'd0);
        reset_n = 1'b1;
        n_str = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rf_write_enable) n_str++;
        end
        check("no_strobe_after_reset", 30'(n_str), 30'd0);

        // load source backpressured while ALU competes every cycle
        idx = 0; cyc = 0; seen_low = 0;
        got.delete();
        while (got.size() < 3 && cyc < 40) begin
            alu_valid = idx < 3; alu_rd = 4; alu_data = 16'(cyc);
            ld_valid = idx < 3;
            ld_rd = idx < 3 ? 3'(5 + idx) : 3'd0;
            ld_data = idx < 3 ? lvals[idx] : 16'h0;
            if (!ld_ready) seen_low = 1;
            hs = ld_valid && ld_ready;
            tick();
            cyc++;
            if (hs) idx++;
            if (rf_write_enable && rf_write_addr >= 3'd5) got.push_back(rf_write_data);
        end
        idle();
        check("ld_ready_dropped", 30'(seen_low), 30'd1);
        for (int i = 0; i < 3; i++)
            check($sformatf("ld_order%0d", i), 30'(got.size() > i ? got[i] : 16'hFFFF), 30'(lvals[i]));

        // randomized traffic against the queue model
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        model_reset();
        for (int c = 0; c < 1500; c++) begin
            alu_valid = $urandom_range(3) != 0; alu_rd = 3'($urandom); alu_data = 16'($urandom);
            ld_valid = $urandom_range(3) != 0; ld_rd = 3'($urandom); ld_data = 16'($urandom);
            flush = $urandom_range(31) == 0;
            model_step();
            tick();
            check($sformatf("rand%0d", c), obs(), model_exp());
        end
        idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
